cp_stripper: RTL and testbench
==============================

CP_STRIPPER -- requirements
Module: cp_stripper

Interface
REQ-001 Parameter ITEM_W, default 32, sc16 sample width (I in [31:16], Q in [15:0]).
REQ-002 Parameter LEN_W, default 13, width of every length/count configuration input.
REQ-003 ce_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 ce_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cfg_fft_len  in  LEN_W  useful samples per OFDM symbol; legal range 1..4096.
REQ-006 cfg_cp_len  in  LEN_W  cyclic-prefix samples to discard per symbol; 0 is legal.
REQ-007 cfg_num_sym  in  LEN_W  symbols per frame, preamble included.
REQ-008 s_axis_tdata/tvalid/tready  in/in/out  ITEM_W/1/1  AXI-Stream input from the Schmidl-Cox detector.
REQ-009 s_axis_tuser  in  1  frame-start flag; high on the first CP sample of a detected frame.
REQ-010 m_axis_tdata/tvalid/tready  out/out/in  ITEM_W/1/1  CP-free sample output toward the FFT.
REQ-011 m_axis_tlast  out  1  high on the last sample of each symbol.
REQ-012 m_axis_tuser  out  1  high on the first output sample of each frame.
REQ-013 stat_frames, stat_dropped  out  32/32  statistics counters (see Configuration).

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CP, DATA, and a transient LATCH folded into the IDLE-exit cycle.
REQ-015 In IDLE, samples SHALL be accepted (s_axis_tready=1) and discarded until a beat with s_axis_tuser=1 is accepted.
REQ-016 On the tuser beat, cfg_fft_len, cfg_cp_len and cfg_num_sym SHALL be latched; config changes mid-frame SHALL have no effect until the next frame.
REQ-017 The tuser beat SHALL count as CP sample 1, or as DATA sample 1 when cp_len=0.
REQ-018 In CP, s_axis_tready SHALL be 1, and each accepted beat SHALL be dropped; after cp_len drops, the FSM SHALL enter DATA.
REQ-019 In DATA, each accepted beat SHALL be forwarded; the fft_len-th beat SHALL carry tlast=1 and SHALL increment the symbol counter.
REQ-020 After the last sample of a symbol, if symbols done == num_sym the FSM SHALL enter IDLE; otherwise it SHALL enter CP, or DATA when cp_len=0.
REQ-021 If num_sym=0 or fft_len=0 is latched, the FSM SHALL remain in IDLE and SHALL forward nothing.
REQ-022 The output SHALL be a registered stage with 1-cycle latency from accepted input to m_axis_tvalid.
REQ-023 In DATA, s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready); a full output register with m_axis_tready=1 SHALL accept a new beat in the same cycle.
REQ-024 Output data, tlast and tuser SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 s_axis_tuser asserted during CP or DATA SHALL be ignored; the current frame SHALL complete unchanged.
REQ-026 s_axis_tuser on the beat immediately after a frame's final sample SHALL start a new frame with no lost beat.

Reset
REQ-027 On ce_rst_n low: state=IDLE, counters=0, m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, stat_*=0, s_axis_tready=0.
REQ-028 Reset mid-frame SHALL discard the partial symbol; after release the block SHALL wait for a new tuser.

Configuration
REQ-029 With macro CP_STRIPPER_STATS_EN defined, stat_frames SHALL count completed frames and stat_dropped SHALL count beats discarded in IDLE and CP; both SHALL saturate at 2^32-1.
REQ-030 Without CP_STRIPPER_STATS_EN, stat_frames and stat_dropped SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-031 Package ofdm_pkg SHALL hold the FSM state enum, LEN_W default, and the sc16 sample typedef.
REQ-032 The output register with ready pass-through SHALL be sub-module ofdm_axis_reg.

Verification
REQ-033 fft=64, cp=16, nsym=2; input ramp 0..199 with tuser on sample 0 -> output 16..79 (tlast at 79, tuser at 16), then 96..159 (tlast at 159); 160..199 dropped.
REQ-034 cp=0, fft=8, nsym=1; tuser on value 5 -> output 5..12, tlast on 12, tuser on 5.
REQ-035 Same as REQ-033 with 25% random m_axis_tready stalls and s_axis_tvalid gaps -> identical output sequence, no duplicated or lost samples.
REQ-036 Extra tuser pulse at input 40 of a REQ-033 frame, plus cfg_fft_len changed to 32 mid-frame -> output identical to REQ-033.
REQ-037 ce_rst_n pulsed low at input 50 of a frame -> outputs 0 during reset; no output until next tuser, then a correct frame.
REQ-038 With CP_STRIPPER_STATS_EN and REQ-033 stimulus -> stat_frames=1, stat_dropped=72 (32 CP + 40 idle); without the macro, both stay 0.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared types for the OFDM receive chain: FSM states, sc16 sample layout, length defaults
// and a saturating counter helper.
package ofdm_pkg;

    localparam int LEN_W_DEF  = 13;
    localparam int ITEM_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_CP    = 2'd2,
        ST_DATA  = 2'd3
    } cp_state_e;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } sc16_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/cp_stripper_if.sv
// AXI-Stream bundle used on both sides of the CP stripper.
interface cp_stripper_if #(
    parameter int ITEM_W = 32
) ();
    logic [ITEM_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/ofdm_axis_reg.sv
// Single output register stage with ready pass-through: a full register drained this cycle
// can be reloaded in the same cycle.
module ofdm_axis_reg #(
    parameter int ITEM_W = 32
) (
    input  logic              ce_clk,
    input  logic              ce_rst_n,
    input  logic              in_vld,
    input  logic [ITEM_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_user,
    output logic              out_ok,
    cp_stripper_if.master     m_axis
);

    logic              vld_q,  vld_d;
    logic [ITEM_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              user_q, user_d;

    assign out_ok = !vld_q || m_axis.tready;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        user_d = user_q;
        if (in_vld) begin
            vld_d  = 1'b1;
            data_d = in_data;
            last_d = in_last;
            user_d = in_user;
        end else if (m_axis.tready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            user_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            user_q <= user_d;
        end
    end

    assign m_axis.tvalid = vld_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tuser  = user_q;

endmodule

// File: rtl/cp_stripper.sv
// Cyclic-prefix stripper: drops CP samples of each OFDM symbol and forwards the useful part.
// Optional statistics counters are built only when CP_STRIPPER_STATS_EN is defined.
module cp_stripper
    import ofdm_pkg::*;
#(
    parameter int ITEM_W = ITEM_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic [LEN_W-1:0] cfg_fft_len,
    input  logic [LEN_W-1:0] cfg_cp_len,
    input  logic [LEN_W-1:0] cfg_num_sym,
    cp_stripper_if.slave     s_axis,
    cp_stripper_if.master    m_axis,
    output logic [31:0]      stat_frames,
    output logic [31:0]      stat_dropped
);

    cp_state_e        state_q, state_d, phase;
    logic [LEN_W-1:0] cnt_q, cnt_d, sym_q, sym_d;
    logic [LEN_W-1:0] fft_q, fft_d, cp_q, cp_d, nsym_q, nsym_d;
    logic             first_q, first_d;

    logic             out_ok, s_ready, fire;
    logic             fwd, fwd_last, fwd_user, drop, frame_done, do_cp, do_data;
    logic [LEN_W-1:0] eff_fft, eff_cp, eff_nsym, cnt_cur, sym_cur, cnt_inc, sym_inc;
    logic             first_cur;

    // A cp_len=0 frame forwards its tuser beat, so IDLE must then respect output backpressure.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE: s_ready = (cfg_cp_len != '0) || out_ok;
            ST_CP:   s_ready = 1'b1;
            ST_DATA: s_ready = out_ok;
            default: s_ready = 1'b0;
        endcase
        s_ready = s_ready && ce_rst_n;
    end

    assign s_axis.tready = s_ready;
    assign fire          = s_axis.tvalid && s_ready;

    // LATCH never occupies a cycle: it is the IDLE cycle that accepts the tuser beat.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_d      = sym_q;
        fft_d      = fft_q;
        cp_d       = cp_q;
        nsym_d     = nsym_q;
        first_d    = first_q;
        fwd        = 1'b0;
        fwd_last   = 1'b0;
        fwd_user   = 1'b0;
        drop       = 1'b0;
        frame_done = 1'b0;
        do_cp      = 1'b0;
        do_data    = 1'b0;

        phase = state_q;
        if (state_q == ST_IDLE && fire && s_axis.tuser) phase = ST_LATCH;

        eff_fft   = (phase == ST_LATCH) ? cfg_fft_len : fft_q;
        eff_cp    = (phase == ST_LATCH) ? cfg_cp_len  : cp_q;
        eff_nsym  = (phase == ST_LATCH) ? cfg_num_sym : nsym_q;
        cnt_cur   = (phase == ST_LATCH) ? '0 : cnt_q;
        sym_cur   = (phase == ST_LATCH) ? '0 : sym_q;
        first_cur = (phase == ST_LATCH) ? 1'b1 : first_q;
        cnt_inc   = cnt_cur + 1'b1;
        sym_inc   = sym_cur + 1'b1;

        if (fire) begin
            case (phase)
                ST_LATCH: begin
                    fft_d  = cfg_fft_len;
                    cp_d   = cfg_cp_len;
                    nsym_d = cfg_num_sym;
                    if (cfg_fft_len == '0 || cfg_num_sym == '0) drop = 1'b1;
                    else if (cfg_cp_len == '0)                  do_data = 1'b1;
                    else                                        do_cp = 1'b1;
                end
                ST_CP:   do_cp   = 1'b1;
                ST_DATA: do_data = 1'b1;
                default: drop    = 1'b1;
            endcase
        end

        if (do_cp) begin
            drop = 1'b1;
            sym_d = sym_cur;
            first_d = first_cur;
            if (cnt_inc == eff_cp) begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end else begin
                state_d = ST_CP;
                cnt_d   = cnt_inc;
            end
        end

        if (do_data) begin
            fwd      = 1'b1;
            fwd_user = first_cur;
            first_d  = 1'b0;
            if (cnt_inc == eff_fft) begin
                fwd_last = 1'b1;
                cnt_d    = '0;
                sym_d    = sym_inc;
                if (sym_inc == eff_nsym) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end else begin
                    state_d = (eff_cp != '0) ? ST_CP : ST_DATA;
                end
            end else begin
                state_d = ST_DATA;
                cnt_d   = cnt_inc;
                sym_d   = sym_cur;
            end
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            fft_q   <= '0;
            cp_q    <= '0;
            nsym_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            fft_q   <= fft_d;
            cp_q    <= cp_d;
            nsym_q  <= nsym_d;
            first_q <= first_d;
        end
    end

    ofdm_axis_reg #(.ITEM_W(ITEM_W)) u_out_reg (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .in_vld   (fwd),
        .in_data  (s_axis.tdata),
        .in_last  (fwd_last),
        .in_user  (fwd_user),
        .out_ok   (out_ok),
        .m_axis   (m_axis)
    );

`ifdef CP_STRIPPER_STATS_EN
    logic [31:0] stat_frames_q, stat_frames_d, stat_dropped_q, stat_dropped_d;

    always_comb begin
        stat_frames_d  = sat_inc32(stat_frames_q, frame_done);
        stat_dropped_d = sat_inc32(stat_dropped_q, drop);
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            stat_frames_q  <= '0;
            stat_dropped_q <= '0;
        end else begin
            stat_frames_q  <= stat_frames_d;
            stat_dropped_q <= stat_dropped_d;
        end
    end

    assign stat_frames  = stat_frames_q;
    assign stat_dropped = stat_dropped_q;
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, drop, frame_done};
    assign stat_frames  = '0;
    assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_cp_stripper.sv
// Randomised self-checking bench for cp_stripper with a frame-position reference model.
module tb_cp_stripper;

    logic        ce_clk = 1'b0;
    logic        ce_rst_n;
    logic [12:0] cfg_fft_len, cfg_cp_len, cfg_num_sym;
    logic [31:0] stat_frames, stat_dropped;

    cp_stripper_if #(.ITEM_W(32)) s_if ();
    cp_stripper_if #(.ITEM_W(32)) m_if ();

    cp_stripper dut (
        .ce_clk       (ce_clk),
        .ce_rst_n     (ce_rst_n),
        .cfg_fft_len  (cfg_fft_len),
        .cfg_cp_len   (cfg_cp_len),
        .cfg_num_sym  (cfg_num_sym),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .stat_frames  (stat_frames),
        .stat_dropped (stat_dropped)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } beat_t;

    beat_t exp_q[$];
    beat_t log_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    stall_en = 0;
    bit    gaps_en  = 0;

    // reference model state: position within the current frame
    bit    in_frame = 0;
    int    pos, m_fft, m_cp, m_nsym;
    int    mdl_frames = 0, mdl_dropped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // output ready driver
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge ce_clk);
            #1;
            m_if.tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // monitor: compare outputs, check hold during stalls, feed the model with accepted inputs
    initial begin
        bit    hold_pend;
        beat_t hold, e;
        int    per, off;
        hold_pend = 0;
        forever begin
            @(negedge ce_clk);
            if (!ce_rst_n) begin
                chk1("rst_m_tvalid", m_if.tvalid, 1'b0);
                chk("rst_m_tdata", m_if.tdata, 32'd0);
                chk1("rst_m_tlast", m_if.tlast, 1'b0);
                chk1("rst_m_tuser", m_if.tuser, 1'b0);
                chk1("rst_s_tready", s_if.tready, 1'b0);
                chk("rst_stat_frames", stat_frames, 32'd0);
                chk("rst_stat_dropped", stat_dropped, 32'd0);
                exp_q.delete();
                log_q.delete();
                in_frame = 0;
                mdl_frames = 0;
                mdl_dropped = 0;
                hold_pend = 0;
            end else begin
                if (hold_pend) begin
                    chk1("hold_tvalid", m_if.tvalid, 1'b1);
                    chk("hold_tdata", m_if.tdata, hold.d);
                    chk1("hold_tlast", m_if.tlast, hold.l);
                    chk1("hold_tuser", m_if.tuser, hold.u);
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0d expected none", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_tdata", m_if.tdata, e.d);
                        chk1("out_tlast", m_if.tlast, e.l);
                        chk1("out_tuser", m_if.tuser, e.u);
                    end
                    log_q.push_back('{d: m_if.tdata, l: m_if.tlast, u: m_if.tuser});
                end
                hold_pend = m_if.tvalid && !m_if.tready;
                hold = '{d: m_if.tdata, l: m_if.tlast, u: m_if.tuser};

                if (s_if.tvalid && s_if.tready) begin
                    if (!in_frame && s_if.tuser && cfg_fft_len != 0 && cfg_num_sym != 0) begin
                        in_frame = 1;
                        m_fft  = int'(cfg_fft_len);
                        m_cp   = int'(cfg_cp_len);
                        m_nsym = int'(cfg_num_sym);
                        pos    = 0;
                    end
                    if (in_frame) begin
                        per = m_cp + m_fft;
                        off = pos % per;
                        if (off < m_cp) mdl_dropped++;
                        else exp_q.push_back('{d: s_if.tdata, l: (off == per - 1), u: (pos == m_cp)});
                        pos++;
                        if (pos == per * m_nsym) begin
                            in_frame = 0;
                            mdl_frames++;
                        end
                    end else begin
                        mdl_dropped++;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic u);
        int  n;
        bit  hs;
        if (gaps_en) begin
            while ($urandom_range(0, 3) == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge ce_clk);
                #1;
            end
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        n = 0;
        forever begin
            @(negedge ce_clk);
            hs = s_if.tready;
            @(posedge ce_clk);
            #1;
            if (hs) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL input_timeout: got no tready expected tready within 1000 cycles");
                break;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    // ramp first..first+n-1; tuser at user_at and user2_at; cfg_fft_len set to 32 from fft_chg_at
    task automatic send_ramp(input int first, input int n, input int user_at, input int user2_at,
                             input int fft_chg_at);
        for (int i = 0; i < n; i++) begin
            if (i == fft_chg_at) cfg_fft_len = 13'd32;
            send_beat(32'(first + i), (i == user_at) || (i == user2_at));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge ce_clk);
        repeat (3) @(posedge ce_clk);
        #1;
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_cfg(input int fft, input int cp, input int nsym);
        cfg_fft_len = 13'(fft);
        cfg_cp_len  = 13'(cp);
        cfg_num_sym = 13'(nsym);
    endtask

    task automatic check_ramp_frame(input string tag);
        chk({tag, "_count"}, 32'(log_q.size()), 32'd128);
        if (log_q.size() == 128) begin
            for (int i = 0; i < 128; i++)
                chk({tag, "_data"}, log_q[i].d, 32'((i < 64) ? 16 + i : 32 + i));
            chk1({tag, "_user16"}, log_q[0].u, 1'b1);
            chk1({tag, "_last79"}, log_q[63].l, 1'b1);
            chk1({tag, "_last159"}, log_q[127].l, 1'b1);
            chk1({tag, "_nolast80"}, log_q[64].l, 1'b0);
        end
        log_q.delete();
    endtask

    initial begin
        int nb, fft, cp, nsym;
        ce_rst_n    = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        set_cfg(64, 16, 2);
        repeat (3) @(posedge ce_clk);
        #1;
        ce_rst_n = 1'b1;
        @(posedge ce_clk);
        #1;

        // basic frame: ramp 0..199
        send_ramp(0, 200, 0, -1, -1);
        drain();
        check_ramp_frame("basic");
`ifdef CP_STRIPPER_STATS_EN
        chk("stat_frames", stat_frames, 32'd1);
        chk("stat_dropped", stat_dropped, 32'd72);
`else
        chk("stat_frames", stat_frames, 32'd0);
        chk("stat_dropped", stat_dropped, 32'd0);
`endif

        // cp=0, tuser on value 5
        set_cfg(8, 0, 1);
        send_ramp(0, 21, 5, -1, -1);
        drain();
        chk("cp0_count", 32'(log_q.size()), 32'd8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("cp0_data", log_q[i].d, 32'(5 + i));
            chk1("cp0_user", log_q[0].u, 1'b1);
            chk1("cp0_last", log_q[7].l, 1'b1);
        end
        log_q.delete();

        // stalls and gaps
        set_cfg(64, 16, 2);
        stall_en = 1;
        gaps_en  = 1;
        send_ramp(0, 200, 0, -1, -1);
        drain();
        check_ramp_frame("stall");

        // spurious tuser and mid-frame config change
        send_ramp(0, 200, 0, 40, 41);
        drain();
        check_ramp_frame("spurious");
        cfg_fft_len = 13'd64;

        // reset mid-frame at input 50
        send_ramp(0, 50, 0, -1, -1);
        ce_rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        repeat (3) @(posedge ce_clk);
        #1;
        ce_rst_n = 1'b1;
        send_ramp(1000, 20, -1, -1, -1);
        drain();
        chk("post_rst_silent", 32'(log_q.size()), 32'd0);
        send_ramp(0, 200, 0, -1, -1);
        drain();
        check_ramp_frame("post_rst");

        // zero symbols latched: nothing forwarded
        set_cfg(8, 2, 0);
        send_ramp(0, 30, 0, -1, -1);
        drain();
        chk("nsym0_silent", 32'(log_q.size()), 32'd0);

        // back-to-back cp=0 frames with tuser right after the final sample
        set_cfg(4, 0, 1);
        for (int f = 0; f < 3; f++) send_ramp(100 * f, 4, 0, -1, -1);
        drain();
        chk("b2b_count", 32'(log_q.size()), 32'd12);
        log_q.delete();

        // randomised frames
        for (int f = 0; f < 25; f++) begin
            fft  = $urandom_range(1, 12);
            cp   = $urandom_range(0, 5);
            nsym = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            set_cfg(fft, cp, nsym);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) send_beat($urandom, 1'b0);
            nb = (nsym == 0) ? 3 : (cp + fft) * nsym;
            for (int i = 0; i < nb; i++) begin
                if (i == 2 && $urandom_range(0, 1) == 1) cfg_fft_len = 13'($urandom_range(1, 12));
                send_beat($urandom, (i == 0) || ($urandom_range(0, 7) == 0));
            end
        end
        drain();
        chk("rand_frames_stat", stat_frames,
`ifdef CP_STRIPPER_STATS_EN
            32'(mdl_frames));
`else
            32'd0);
`endif
        chk("rand_dropped_stat", stat_dropped,
`ifdef CP_STRIPPER_STATS_EN
            32'(mdl_dropped));
`else
            32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
